encoder_2x1: RTL and testbench

//   One-hot 2-to-1 binary encoder with a registered output stage.

---
 rtl/encoder_2x1.sv | 82 ++++++++
 tb/tb_encoder_2x1.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/encoder_2x1.sv
// One-hot 2-to-1 encoder with registered OUT/valid/err and saturating illegal-code counter; 1 clk latency, no backpressure.
// ENCODER_2X1_PRIORITY_EN: when defined, IN=2'b11 resolves to the MSB instead of being flagged illegal.
module encoder_2x1 #(
  parameter bit          HOLD_ON_INVALID = 1'b1,
  parameter int unsigned ERR_CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           IN,
  output logic                 OUT,
  output logic                 valid,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic                 legal;
  logic                 illegal;
  logic                 idx;
  logic                 out_d, out_q;
  logic                 valid_d, valid_q;
  logic                 err_d, err_q;
  logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

  always_comb begin
    legal   = 1'b0;
    illegal = 1'b0;
    idx     = 1'b0;
    case (IN)
      2'b01: begin
        legal = 1'b1;
        idx   = 1'b0;
      end
      2'b10: begin
        legal = 1'b1;
        idx   = 1'b1;
      end
      2'b11: begin
`ifdef ENCODER_2X1_PRIORITY_EN
        legal = 1'b1;
        idx   = 1'b1;
`else
        illegal = 1'b1;
`endif
      end
      default: begin
        legal   = 1'b0;
        illegal = 1'b0;
      end
    endcase
  end

  always_comb begin
    out_d     = legal ? idx : (HOLD_ON_INVALID ? out_q : 1'b0);
    valid_d   = legal;
    err_d     = illegal;
    err_cnt_d = err_cnt_q;
    // saturate at all-ones rather than wrapping
    if (illegal && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      out_q     <= out_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign OUT     = out_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_encoder_2x1.sv
// Bench for encoder_2x1: three instances (hold/W=8, no-hold/W=8, hold/W=2) driven in lockstep.
module tb_encoder_2x1;

`ifdef ENCODER_2X1_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] in_v = 2'b00;

  logic       out_a, valid_a, err_a;
  logic [7:0] cnt_a;
  logic       out_b, valid_b, err_b;
  logic [7:0] cnt_b;
  logic       out_c, valid_c, err_c;
  logic [1:0] cnt_c;

  always #5 clk = ~clk;

  encoder_2x1 #(.HOLD_ON_INVALID(1'b1), .ERR_CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .IN(in_v), .OUT(out_a), .valid(valid_a), .err(err_a), .err_cnt(cnt_a));
  encoder_2x1 #(.HOLD_ON_INVALID(1'b0), .ERR_CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .IN(in_v), .OUT(out_b), .valid(valid_b), .err(err_b), .err_cnt(cnt_b));
  encoder_2x1 #(.HOLD_ON_INVALID(1'b1), .ERR_CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .IN(in_v), .OUT(out_c), .valid(valid_c), .err(err_c), .err_cnt(cnt_c));

  typedef struct {
    logic       rst;
    logic [1:0] in;
    logic       out;
    logic       valid;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  typedef struct {
    logic       out_a;
    logic       valid;
    logic       err;
    logic [7:0] cnt_a;
    logic       out_b;
    logic [7:0] cnt_b;
    logic       out_c;
    logic [1:0] cnt_c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference state for the no-hold and narrow-counter instances
  logic       m_out_b = 1'b0;
  logic [7:0] m_cnt_b = 8'd0;
  logic       m_out_c = 1'b0;
  logic [1:0] m_cnt_c = 2'd0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] i, input logic e_out, input logic e_valid,
                      input logic e_err, input logic [7:0] e_cnt);
    exp_t e;
    logic lg, is_err;
    @(negedge clk);
    rst  = r;
    in_v = i;
    lg     = (i == 2'b01) || (i == 2'b10) || (PRIO && i == 2'b11);
    is_err = (i == 2'b11) && !PRIO;
    if (r) begin
      m_out_b = 1'b0; m_cnt_b = 8'd0; m_out_c = 1'b0; m_cnt_c = 2'd0;
    end else begin
      m_out_b = lg ? i[1] : 1'b0;
      if (lg) m_out_c = i[1];
      if (is_err && m_cnt_b != 8'hFF) m_cnt_b = m_cnt_b + 8'd1;
      if (is_err && m_cnt_c != 2'd3) m_cnt_c = m_cnt_c + 2'd1;
    end
    e.out_a = e_out; e.valid = e_valid; e.err = e_err; e.cnt_a = e_cnt;
    e.out_b = m_out_b; e.cnt_b = m_cnt_b; e.out_c = m_out_c; e.cnt_c = m_cnt_c;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("out_a",   {7'd0, out_a},   {7'd0, e.out_a});
    chk("valid_a", {7'd0, valid_a}, {7'd0, e.valid});
    chk("err_a",   {7'd0, err_a},   {7'd0, e.err});
    chk("cnt_a",   cnt_a,           e.cnt_a);
    chk("out_b",   {7'd0, out_b},   {7'd0, e.out_b});
    chk("valid_b", {7'd0, valid_b}, {7'd0, e.valid});
    chk("err_b",   {7'd0, err_b},   {7'd0, e.err});
    chk("cnt_b",   cnt_b,           e.cnt_b);
    chk("out_c",   {7'd0, out_c},   {7'd0, e.out_c});
    chk("valid_c", {7'd0, valid_c}, {7'd0, e.valid});
    chk("err_c",   {7'd0, err_c},   {7'd0, e.err});
    chk("cnt_c",   {6'd0, cnt_c},   {6'd0, e.cnt_c});
  endtask

  initial begin
    vec_t tbl[14];
    // expectations for the hold/W=8 instance; IN=2'b11 rows depend on the build
    tbl[0]  = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 2'b11, 1'b1, PRIO, !PRIO, PRIO ? 8'd0 : 8'd1};
    tbl[7]  = '{1'b0, 2'b11, 1'b1, PRIO, !PRIO, PRIO ? 8'd0 : 8'd2};
    tbl[8]  = '{1'b0, 2'b11, 1'b1, PRIO, !PRIO, PRIO ? 8'd0 : 8'd3};
    tbl[9]  = '{1'b0, 2'b01, 1'b0, 1'b1, 1'b0, PRIO ? 8'd0 : 8'd3};
    tbl[10] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, PRIO ? 8'd0 : 8'd3};
    tbl[11] = '{1'b0, 2'b11, PRIO, PRIO, !PRIO, PRIO ? 8'd0 : 8'd4};
    tbl[12] = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[13] = '{1'b0, 2'b11, PRIO, PRIO, !PRIO, PRIO ? 8'd0 : 8'd1};

    for (int k = 0; k < 14; k++) begin
      step(tbl[k].rst, tbl[k].in, tbl[k].out, tbl[k].valid, tbl[k].err, tbl[k].cnt);
    end

    // saturation of the 2-bit counter under a run of illegal codes
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 2'b11, PRIO, PRIO, !PRIO, PRIO ? 8'd0 : 8'(k));
      chk("sat_cnt_c", {6'd0, cnt_c}, PRIO ? 8'd0 : ((k < 3) ? 8'(k) : 8'd3));
    end

    // reset while an illegal code is present, then counting restarts from 1
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("rst_mid_cnt_c", {6'd0, cnt_c}, 8'd0);
    step(1'b0, 2'b11, PRIO, PRIO, !PRIO, PRIO ? 8'd0 : 8'd1);
    chk("resume_cnt_c", {6'd0, cnt_c}, PRIO ? 8'd0 : 8'd1);

    // return to idle with hold and no-hold behaviour visible
    step(1'b0, 2'b10, 1'b1, 1'b1, 1'b0, PRIO ? 8'd0 : 8'd1);
    step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, PRIO ? 8'd0 : 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
